// File: rtl/writeback_arbiter_if.sv
// Write-back request, reservation and register-cell signals shared by the arbiter and its users.
// The arbiter attaches through the slave modport; the functional units and decode side use master.
interface writeback_arbiter_if #(
   parameter int NUM_UNITS      = 4,
   parameter int REGISTER_COUNT = 16,
   parameter int INDEX_WIDTH    = 4,
   parameter int OPERAND_WIDTH  = 32
);
   logic [NUM_UNITS-1:0]               req_valid;
   logic [NUM_UNITS-1:0]               req_ready;
   logic [NUM_UNITS*INDEX_WIDTH-1:0]   req_index;
   logic [NUM_UNITS*OPERAND_WIDTH-1:0] req_data;
   logic                               rsv_valid;
   logic [INDEX_WIDTH-1:0]             rsv_index;
   logic [REGISTER_COUNT-1:0]          reserved_status;
   logic [REGISTER_COUNT-1:0]          write_reserve;
   logic [REGISTER_COUNT-1:0]          write_back;
   logic [OPERAND_WIDTH-1:0]           wb_data;
   logic                               err_index;
   logic                               err_unreserved;

   modport slave (
      input  req_valid, req_index, req_data, rsv_valid, rsv_index, reserved_status,
      output req_ready, write_reserve, write_back, wb_data, err_index, err_unreserved
   );

   modport master (
      output req_valid, req_index, req_data, rsv_valid, rsv_index, reserved_status,
      input  req_ready, write_reserve, write_back, wb_data, err_index, err_unreserved
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register file's single write-back path among NUM_UNITS units.
// Reserve and write-back one-hots leave through one register stage so they reach the cells aligned.
module writeback_arbiter #(
   parameter int NUM_UNITS      = 4,
   parameter int REGISTER_COUNT = 16,
   parameter int INDEX_WIDTH    = 4,
   parameter int OPERAND_WIDTH  = 32
) (
   input logic                clk,
   input logic                rst,
   writeback_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   logic [PTR_W-1:0]          ptr_q, ptr_d;
   logic [REGISTER_COUNT-1:0] write_reserve_q, write_reserve_d;
   logic [REGISTER_COUNT-1:0] write_back_q, write_back_d;
   logic [OPERAND_WIDTH-1:0]  wb_data_q, wb_data_d;
   logic                      err_index_q, err_index_d;
   logic                      err_unreserved_q, err_unreserved_d;

   logic [NUM_UNITS-1:0]      eligible;
   logic [NUM_UNITS-1:0]      grant_onehot;
   logic                      grant_vld;
   logic [PTR_W-1:0]          grant_sel;
   logic [INDEX_WIDTH-1:0]    grant_index;
   logic [OPERAND_WIDTH-1:0]  grant_data;
   logic [REGISTER_COUNT-1:0] effective_reserved;

   function automatic logic in_range(input logic [INDEX_WIDTH-1:0] idx);
      return int'(idx) < REGISTER_COUNT;
   endfunction

   function automatic logic [REGISTER_COUNT-1:0] onehot(input logic [INDEX_WIDTH-1:0] idx);
      logic [REGISTER_COUNT-1:0] v;
      v = '0;
      if (in_range(idx)) v = REGISTER_COUNT'(1) << idx;
      return v;
   endfunction

   // A unit colliding with this cycle's reservation is held off, since the cell would drop its write.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      eligible     = '0;
      grant_onehot = '0;
      grant_vld    = 1'b0;
      grant_sel    = '0;
      grant_index  = '0;
      grant_data   = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         eligible[i] = bus.req_valid[i] &&
                       !(bus.rsv_valid && bus.rsv_index == bus.req_index[i*INDEX_WIDTH +: INDEX_WIDTH]);
      end
      // First pass covers pointer..top, second pass wraps around to the units below the pointer.
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (!grant_vld && eligible[i] && i >= int'(ptr_q)) begin
            grant_vld   = 1'b1;
            grant_sel   = PTR_W'(i);
            grant_index = bus.req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
            grant_data  = bus.req_data[i*OPERAND_WIDTH +: OPERAND_WIDTH];
         end
      end
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (!grant_vld && eligible[i]) begin
            grant_vld   = 1'b1;
            grant_sel   = PTR_W'(i);
            grant_index = bus.req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
            grant_data  = bus.req_data[i*OPERAND_WIDTH +: OPERAND_WIDTH];
         end
      end
      for (int i = 0; i < NUM_UNITS; i++) begin
         grant_onehot[i] = grant_vld && (grant_sel == PTR_W'(i));
      end
   end

   always_comb begin
      ptr_d            = ptr_q;
      wb_data_d        = wb_data_q;
      err_index_d      = err_index_q;
      err_unreserved_d = err_unreserved_q;
      write_back_d     = '0;
      write_reserve_d  = bus.rsv_valid ? onehot(bus.rsv_index) : '0;
      // Reservation state as the cells will hold it once the pulses already in flight land.
      effective_reserved = (bus.reserved_status & ~write_back_q) | write_reserve_q;

      if (bus.rsv_valid && !in_range(bus.rsv_index)) err_index_d = 1'b1;

      if (grant_vld) begin
         write_back_d = onehot(grant_index);
         wb_data_d    = grant_data;
         ptr_d        = (grant_sel == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_sel + 1'b1;
         if (!in_range(grant_index)) begin
            err_index_d = 1'b1;
         end else if ((effective_reserved & onehot(grant_index)) == '0) begin
            err_unreserved_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q            <= '0;
         write_reserve_q  <= '0;
         write_back_q     <= '0;
         wb_data_q        <= '0;
         err_index_q      <= 1'b0;
         err_unreserved_q <= 1'b0;
      end else begin
         ptr_q            <= ptr_d;
         write_reserve_q  <= write_reserve_d;
         write_back_q     <= write_back_d;
         wb_data_q        <= wb_data_d;
         err_index_q      <= err_index_d;
         err_unreserved_q <= err_unreserved_d;
      end
   end

   assign bus.req_ready      = grant_onehot;
   assign bus.write_reserve  = write_reserve_q;
   assign bus.write_back     = write_back_q;
   assign bus.wb_data        = wb_data_q;
   assign bus.err_index      = err_index_q;
   assign bus.err_unreserved = err_unreserved_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reserve pulses, grants, round-robin order, collision hold-off,
// sticky errors and mid-operation reset. INDEX_WIDTH is 5 so out-of-range indices can be driven.
module tb_writeback_arbiter;
   localparam int NU = 4;
   localparam int RC = 16;
   localparam int IW = 5;
   localparam int OW = 32;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   writeback_arbiter_if #(
      .NUM_UNITS(NU), .REGISTER_COUNT(RC), .INDEX_WIDTH(IW), .OPERAND_WIDTH(OW)
   ) bus ();

   writeback_arbiter #(
      .NUM_UNITS(NU), .REGISTER_COUNT(RC), .INDEX_WIDTH(IW), .OPERAND_WIDTH(OW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int u, input logic v, input logic [IW-1:0] idx, input logic [OW-1:0] d);
      bus.req_valid[u]            = v;
      bus.req_index[u*IW +: IW]   = idx;
      bus.req_data[u*OW +: OW]    = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [NU-1:0] exp_rdy;
      logic [RC-1:0] exp_wb;
      int            u;

      rst                 = 1'b1;
      bus.req_valid       = '0;
      bus.req_index       = '0;
      bus.req_data        = '0;
      bus.rsv_valid       = 1'b0;
      bus.rsv_index       = '0;
      bus.reserved_status = '0;
      tick();
      tick();
      check("rst_write_reserve", bus.write_reserve, 16'h0000);
      check("rst_write_back", bus.write_back, 16'h0000);
      check("rst_wb_data", bus.wb_data, 32'h0);
      check("rst_err_index", bus.err_index, 1'b0);
      check("rst_err_unreserved", bus.err_unreserved, 1'b0);
      rst = 1'b0;

      // Single reservation of r5: one pulse, nothing else moves.
      bus.rsv_valid = 1'b1;
      bus.rsv_index = 5'd5;
      #1;
      check("t1_ready_idle", bus.req_ready, 4'b0000);
      tick();
      check("t1_reserve_pulse", bus.write_reserve, 16'h0020);
      check("t1_wb_idle", bus.write_back, 16'h0000);
      check("t1_data_idle", bus.wb_data, 32'h0);
      bus.rsv_valid = 1'b0;
      tick();
      check("t1_reserve_single", bus.write_reserve, 16'h0000);

      // Reserve r3, let it land in the cell, then unit 1 writes it back.
      bus.rsv_valid = 1'b1;
      bus.rsv_index = 5'd3;
      tick();
      check("t2_reserve_pulse", bus.write_reserve, 16'h0008);
      bus.rsv_valid = 1'b0;
      tick();
      bus.reserved_status = 16'h0028;
      set_req(1, 1'b1, 5'd3, 32'hDEADBEEF);
      #1;
      check("t2_ready", bus.req_ready, 4'b0010);
      tick();
      check("t2_write_back", bus.write_back, 16'h0008);
      check("t2_wb_data", bus.wb_data, 32'hDEADBEEF);
      check("t2_err_unreserved", bus.err_unreserved, 1'b0);
      set_req(1, 1'b0, 5'd0, 32'h0);
      bus.reserved_status = 16'h0020;
      tick();
      check("t2_wb_single", bus.write_back, 16'h0000);
      check("t2_data_hold", bus.wb_data, 32'hDEADBEEF);

      // All units continuously valid on r10..r13; pointer sits at 2 after the unit-1 grant.
      bus.reserved_status = 16'h3C20;
      for (int i = 0; i < NU; i++) set_req(i, 1'b1, IW'(10 + i), OW'(32'hA000_0000 + i));
      for (int k = 0; k < 8; k++) begin
         u       = (2 + k) % NU;
         exp_rdy = 4'b0001 << u;
         exp_wb  = 16'h0001 << (10 + u);
         #1;
         check($sformatf("t3_ready_%0d", k), bus.req_ready, exp_rdy);
         tick();
         check($sformatf("t3_write_back_%0d", k), bus.write_back, exp_wb);
         check($sformatf("t3_wb_data_%0d", k), bus.wb_data, OW'(32'hA000_0000 + u));
      end
      for (int i = 0; i < NU; i++) set_req(i, 1'b0, 5'd0, 32'h0);
      bus.reserved_status = 16'h0020;
      tick();
      check("t3_check_clean", bus.err_unreserved, 1'b0);

      // Unit 2 collides with a reservation of r7, then goes through once decode is quiet.
      bus.reserved_status = 16'h0020;
      set_req(2, 1'b1, 5'd7, 32'h7777_0007);
      bus.rsv_valid = 1'b1;
      bus.rsv_index = 5'd7;
      #1;
      check("t4_ready_blocked", bus.req_ready, 4'b0000);
      tick();
      check("t4_reserve_only", bus.write_reserve, 16'h0080);
      check("t4_no_write_back", bus.write_back, 16'h0000);
      bus.rsv_valid = 1'b0;
      #1;
      check("t4_ready_retry", bus.req_ready, 4'b0100);
      tick();
      bus.reserved_status = 16'h00A0;
      check("t4_write_back", bus.write_back, 16'h0080);
      check("t4_wb_data", bus.wb_data, 32'h7777_0007);
      check("t4_err_unreserved", bus.err_unreserved, 1'b0);
      check("t4_err_index", bus.err_index, 1'b0);
      set_req(2, 1'b0, 5'd0, 32'h0);

      // Write-back to unreserved r9 (pointer at 3, wraps to unit 0).
      bus.reserved_status = 16'h0020;
      set_req(0, 1'b1, 5'd9, 32'h9999_0009);
      #1;
      check("t5_ready_u0", bus.req_ready, 4'b0001);
      tick();
      check("t5_write_back", bus.write_back, 16'h0200);
      check("t5_err_unreserved", bus.err_unreserved, 1'b1);
      check("t5_err_index_clear", bus.err_index, 1'b0);
      set_req(0, 1'b0, 5'd0, 32'h0);

      // Out-of-range reservation.
      bus.rsv_valid = 1'b1;
      bus.rsv_index = 5'd20;
      tick();
      check("t5_rsv_oor_pulse", bus.write_reserve, 16'h0000);
      check("t5_err_index", bus.err_index, 1'b1);
      bus.rsv_valid = 1'b0;

      // Out-of-range write-back from unit 1: consumed, data taken, no one-hot bit.
      set_req(1, 1'b1, 5'd17, 32'h1717_0017);
      #1;
      check("t5_ready_oor", bus.req_ready, 4'b0010);
      tick();
      check("t5_wb_oor", bus.write_back, 16'h0000);
      check("t5_data_oor", bus.wb_data, 32'h1717_0017);
      set_req(1, 1'b0, 5'd0, 32'h0);

      // Reserve r4 and write back r12 in the same cycle.
      bus.reserved_status = 16'h1020;
      bus.rsv_valid       = 1'b1;
      bus.rsv_index       = 5'd4;
      set_req(2, 1'b1, 5'd12, 32'hCCCC_000C);
      #1;
      check("t5_ready_both", bus.req_ready, 4'b0100);
      tick();
      check("t5_both_reserve", bus.write_reserve, 16'h0010);
      check("t5_both_write_back", bus.write_back, 16'h1000);
      bus.rsv_valid = 1'b0;
      set_req(2, 1'b0, 5'd0, 32'h0);
      tick();
      tick();
      check("t5_sticky_unreserved", bus.err_unreserved, 1'b1);
      check("t5_sticky_index", bus.err_index, 1'b1);

      // Reset while a grant sits in the output stage.
      bus.reserved_status = 16'h0800;
      set_req(2, 1'b1, 5'd11, 32'hBBBB_000B);
      #1;
      check("t6_ready_u2", bus.req_ready, 4'b0100);
      tick();
      check("t6_stage_loaded", bus.write_back, 16'h0800);
      set_req(2, 1'b0, 5'd0, 32'h0);
      rst = 1'b1;
      tick();
      check("t6_write_back", bus.write_back, 16'h0000);
      check("t6_write_reserve", bus.write_reserve, 16'h0000);
      check("t6_wb_data", bus.wb_data, 32'h0);
      check("t6_err_index", bus.err_index, 1'b0);
      check("t6_err_unreserved", bus.err_unreserved, 1'b0);
      rst = 1'b0;
      bus.reserved_status = 16'h3C00;
      for (int i = 0; i < NU; i++) set_req(i, 1'b1, IW'(10 + i), OW'(32'hE000_0000 + i));
      #1;
      check("t6_ptr_reset", bus.req_ready, 4'b0001);
      tick();
      check("t6_first_wb", bus.write_back, 16'h0400);
      for (int i = 0; i < NU; i++) set_req(i, 1'b0, 5'd0, 32'h0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Shares the register file's single write-back path among NUM_UNITS functional units.
- Sequences write-reserve requests from decode into the per-register cells.
- Drives each cell's one-hot write_reserve / write_back inputs and the common write-back data bus through one registered output stage, so reserve and write-back reach the cells aligned.
- Never lets a reservation and a write-back hit the same register on the same edge, because the cell gives reserve priority and would silently drop the write-back.

Parameters:
NUM_UNITS, 4, number of write-back requesters
REGISTER_COUNT, 16, number of register cells
INDEX_WIDTH, 4, register index width (>= $clog2(REGISTER_COUNT))
OPERAND_WIDTH, 32, data width of a register cell

Ports:
clk  input  1  clock
rst  input  1  reset
req_valid  input  NUM_UNITS  unit i has a result to write back
req_ready  output  NUM_UNITS  unit i granted this cycle
req_index  input  NUM_UNITS*INDEX_WIDTH  destination index, unit i at slice i
req_data  input  NUM_UNITS*OPERAND_WIDTH  result data, unit i at slice i
rsv_valid  input  1  decode reserves a destination this cycle
rsv_index  input  INDEX_WIDTH  register to reserve
reserved_status  input  REGISTER_COUNT  write_reserve_output of each cell
write_reserve  output  REGISTER_COUNT  one-hot to cell write_reserve_input
write_back  output  REGISTER_COUNT  one-hot to cell write_back_input
wb_data  output  OPERAND_WIDTH  common data_input for all cells
err_index  output  1  sticky: index >= REGISTER_COUNT seen
err_unreserved  output  1  sticky: write-back to unreserved register

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: write_reserve=0, write_back=0, wb_data=0, err_index=0, err_unreserved=0, round-robin pointer=0.
- Reset mid-operation: any in-flight output stage is discarded, and no cell sees a pulse on the following edge.
- Handshake:
  - req_ready is combinational from the current-cycle inputs and the pointer.
  - A transfer happens when req_valid[i] && req_ready[i].
  - A unit holds valid, index and data stable until it is accepted.
  - At most one req_ready bit is high per cycle.
- Eligibility: unit i is eligible iff req_valid[i] && !(rsv_valid && rsv_index == req_index[i]).
  - A blocked unit waits and retries; it is not dropped.
- Round-robin selection:
  - Search starts at the pointer and proceeds upward with wrap; the first eligible unit is granted.
  - After a grant to unit g, pointer <= (g+1) mod NUM_UNITS.
  - With no grant, the pointer is unchanged.
- Output stage (1-cycle latency, registered on the edge after the request cycle):
  - write_back <= onehot(req_index[g]) if a grant occurred, else 0.
  - wb_data <= req_data[g] on a grant; otherwise it holds its previous value.
  - write_reserve <= onehot(rsv_index) if rsv_valid, else 0.
  - Each output is a single-cycle pulse.
  - The cell updates one edge after the output pulse, so a reserve takes effect 2 edges after rsv_valid.
- Reservations are always accepted; there is no backpressure on decode.
- Out-of-range index (>= REGISTER_COUNT) on a reservation or a granted write-back:
  - The transaction is still consumed and err_index <= 1.
  - No one-hot bit is set.
- Unreserved check at grant time:
  - effective_reserved = (reserved_status & ~write_back) | write_reserve, using the current output-register values.
  - If bit req_index[g] of effective_reserved is 0, set err_unreserved <= 1; the write-back is still issued.
- Sticky errors: both err bits clear only on reset.
- Simultaneous reserve and grant to different registers: both are issued in the same output cycle.

Test Plan:
- Reset, then rsv_valid=1 rsv_index=5 for one cycle -> write_reserve==16'h0020 for exactly one cycle on the next edge; all other outputs 0.
- Reserve r3, wait 2 cycles; unit 1 requests idx 3 data 32'hDEADBEEF -> req_ready=4'b0010 the same cycle; next edge write_back==16'h0008, wb_data==32'hDEADBEEF; err_unreserved stays 0.
- All 4 units valid continuously, each on its own reserved register -> grant order 0,1,2,3,0,1,… with one grant per cycle and no unit starved.
- Unit 2 requests idx 7 while rsv_valid with rsv_index=7 -> req_ready[2]=0 that cycle and write_reserve==onehot(7) only; with rsv_valid deasserted the next cycle, unit 2 is granted.
- Write-back to unreserved idx 9 -> err_unreserved=1 and the write-back is still issued. Separately, rsv_index=20 with REGISTER_COUNT=16 -> err_index=1 and write_reserve==0. Both bits stay set until rst.
- Assert rst for one cycle while a grant is in the output stage -> write_back==0 on the next edge, pointer=0, errors cleared; the next request from unit 0 is granted first.
